mac_learn_lookup: RTL and testbench



---
 rtl/switch_pkg.sv | 36 +++
 rtl/mac_learn_lookup.sv | 112 +++++++++++
 tb/tb_mac_learn_lookup.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared switch types and helpers: port/MAC typedefs, table entry layout,
// MAC hashing and multicast classification.
package switch_pkg;

  localparam int unsigned NUM_PORTS   = 4;
  localparam int unsigned PORT_W      = $clog2(NUM_PORTS);
  // Upper bound on the per-entry age width; instances use only the low bits.
  localparam int unsigned ENTRY_AGE_W = 8;

  typedef logic [47:0]          mac_t;
  typedef logic [PORT_W-1:0]    port_t;
  typedef logic [NUM_PORTS-1:0] port_mask_t;

  typedef struct packed {
    logic                   valid;
    mac_t                   mac;
    port_t                  port;
    logic [ENTRY_AGE_W-1:0] age;
  } entry_t;

  // XOR of consecutive idx_w-bit slices, LSB first; top slice zero-padded.
  function automatic logic [15:0] mac_hash(input mac_t mac, input int unsigned idx_w);
    logic [15:0] h;
    h = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      h[4'(i % idx_w)] ^= mac[6'(i)];
    end
    return h;
  endfunction

  // I/G bit of the first octet on the wire.
  function automatic logic is_multicast(input mac_t mac);
    return mac[40];
  endfunction

endpackage

// File: rtl/mac_learn_lookup.sv
// Source-MAC learning and destination lookup over a direct-mapped flop table,
// producing a per-frame egress port mask with aging and global flush.
module mac_learn_lookup
  import switch_pkg::*;
#(
  parameter int unsigned TABLE_DEPTH = 64,
  parameter int unsigned AGE_WIDTH   = 2
) (
  input  logic                  switch_clk,
  input  logic                  switch_rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [47:0]           req_dst_mac_i,
  input  logic [47:0]           req_src_mac_i,
  input  logic [PORT_W-1:0]     req_src_port_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [NUM_PORTS-1:0]  resp_port_mask_o,
  output logic                  resp_hit_o,
  output logic                  learn_evict_o,
  input  logic                  age_tick_i,
  input  logic                  flush_i
);

  localparam int unsigned IDX_W = $clog2(TABLE_DEPTH);
  localparam logic [ENTRY_AGE_W-1:0] AGE_MAX = ENTRY_AGE_W'((1 << AGE_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t           state_q, state_d;
  entry_t           table_q [TABLE_DEPTH];
  mac_t             dst_q, src_q;
  port_t            port_q;
  logic [IDX_W-1:0] dst_idx, src_idx;
  port_mask_t       mask_d;
  logic             hit_d, learn_en, evict;

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads see pre-write table contents; the learn lands on the closing edge.
  always_comb begin
    dst_idx = IDX_W'(mac_hash(dst_q, IDX_W));
    src_idx = IDX_W'(mac_hash(src_q, IDX_W));
    mask_d  = '1;
    mask_d[port_q] = 1'b0;
    hit_d   = 1'b0;
    if (!is_multicast(dst_q) && table_q[dst_idx].valid && table_q[dst_idx].mac == dst_q) begin
      hit_d  = 1'b1;
      mask_d = '0;
      if (table_q[dst_idx].port != port_q) mask_d[table_q[dst_idx].port] = 1'b1;
    end
    learn_en = (state_q == LOOKUP) && !is_multicast(src_q) && !flush_i;
    evict    = learn_en && table_q[src_idx].valid && table_q[src_idx].mac != src_q;
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      state_q          <= IDLE;
      dst_q            <= '0;
      src_q            <= '0;
      port_q           <= '0;
      resp_port_mask_o <= '0;
      resp_hit_o       <= 1'b0;
      learn_evict_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      learn_evict_o <= evict;
      if (state_q == IDLE && req_valid_i) begin
        dst_q  <= req_dst_mac_i;
        src_q  <= req_src_mac_i;
        port_q <= req_src_port_i;
      end
      if (state_q == LOOKUP) begin
        resp_port_mask_o <= mask_d;
        resp_hit_o       <= hit_d;
      end
    end
  end

  // Priority: flush over everything, then learn over aging for the same entry.
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) table_q[i] <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) table_q[i].valid <= 1'b0;
    end else begin
      if (age_tick_i) begin
        for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
          if (table_q[i].valid) begin
            if (table_q[i].age != '0) table_q[i].age <= table_q[i].age - ENTRY_AGE_W'(1);
            else                      table_q[i].valid <= 1'b0;
          end
        end
      end
      if (learn_en) begin
        table_q[src_idx] <= '{valid: 1'b1, mac: src_q, port: port_q, age: AGE_MAX};
      end
    end
  end

endmodule

// File: tb/tb_mac_learn_lookup.sv
// Self-checking bench for mac_learn_lookup: vector table plus hand sequences
// for aging, collision, flush, backpressure and reset.
module tb_mac_learn_lookup;
  import switch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, resp_valid, resp_ready, resp_hit, evict_o;
  logic       age_tick, flush;
  mac_t       dst, src;
  port_t      sport;
  port_mask_t resp_mask;

  mac_learn_lookup #(.TABLE_DEPTH(64), .AGE_WIDTH(2)) dut (
    .switch_clk(clk), .switch_rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dst_mac_i(dst), .req_src_mac_i(src), .req_src_port_i(sport),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_port_mask_o(resp_mask), .resp_hit_o(resp_hit),
    .learn_evict_o(evict_o), .age_tick_i(age_tick), .flush_i(flush)
  );

  always #5 clk = ~clk;

  localparam mac_t A  = 48'h1234_5678_9A00;
  localparam mac_t B  = 48'h1234_5678_9A41;  // same hash as A: bits 0 and 6 flipped
  localparam mac_t C  = 48'hAABB_CCDD_EE01;
  localparam mac_t D0 = 48'hAABB_CCDD_EE00;
  localparam mac_t BC = 48'hFFFF_FFFF_FFFF;
  localparam mac_t MC = 48'h0100_5E00_0001;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int evict_cnt = 0;
  logic prev_valid = 1'b0;
  logic [4:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Inputs only change 2ns after a rising edge, so negedge sampling is race-free.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req_valid && req_ready) accept_cyc = cyc;
      if (evict_o) evict_cnt++;
      if (resp_valid && !prev_valid) chk("latency", 32'(cyc - accept_cyc), 32'd2);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 32'({resp_hit, resp_mask}), 32'h1F);
        else chk("resp_hit_mask", 32'({resp_hit, resp_mask}), 32'(exp_q.pop_front()));
      end
      prev_valid = resp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) return;
      step();
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ev: 0 nothing, 1 age tick during LOOKUP, 2 flush during LOOKUP
  task automatic send(input port_t p, input mac_t d, input mac_t s,
                      input logic [3:0] m, input logic h, input int ev, input bit wait_done);
    exp_q.push_back({h, m});
    req_valid = 1'b1; dst = d; src = s; sport = p;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    age_tick  = (ev == 1);
    flush     = (ev == 2);
    step();
    age_tick = 1'b0;
    flush    = 1'b0;
    if (wait_done) drain();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      age_tick = 1'b1;
      step();
      age_tick = 1'b0;
      step();
    end
  endtask

  task automatic wait_resp_valid();
    for (int i = 0; i < 20 && !resp_valid; i++) step();
    chk("resp_valid_wait", 32'(resp_valid), 32'd1);
  endtask

  typedef struct {
    port_t      p;
    mac_t       d;
    mac_t       s;
    logic [3:0] m;
    logic       h;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{p: 2'd0, d: D0, s: A,  m: 4'b1110, h: 1'b0};
    vecs[1] = '{p: 2'd1, d: A,  s: C,  m: 4'b0001, h: 1'b1};
    vecs[2] = '{p: 2'd0, d: C,  s: A,  m: 4'b0010, h: 1'b1};
    vecs[3] = '{p: 2'd0, d: A,  s: A,  m: 4'b0000, h: 1'b1};
    vecs[4] = '{p: 2'd1, d: BC, s: MC, m: 4'b1101, h: 1'b0};
    vecs[5] = '{p: 2'd0, d: MC, s: A,  m: 4'b1110, h: 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; age_tick = 1'b0; flush = 1'b0;
    dst = '0; src = '0; sport = '0;
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mask",       32'(resp_mask),  32'd0);
    chk("rst_hit",        32'(resp_hit),   32'd0);
    chk("rst_evict",      32'(evict_o),    32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) send(vecs[i].p, vecs[i].d, vecs[i].s, vecs[i].m, vecs[i].h, 0, 1'b1);

    // Aging: A at age 3 survives three ticks, dies on the fourth.
    ticks(3);
    send(2'd1, A, C, 4'b0001, 1'b1, 0, 1'b1);
    ticks(1);
    send(2'd1, A, C, 4'b1101, 1'b0, 0, 1'b1);
    // Learn of A coinciding with a tick must leave A at full age.
    send(2'd0, C, A, 4'b0010, 1'b1, 0, 1'b1);
    ticks(3);
    send(2'd0, C, A, 4'b0010, 1'b1, 1, 1'b1);
    send(2'd1, A, MC, 4'b0001, 1'b1, 0, 1'b1);
    send(2'd0, C, MC, 4'b1110, 1'b0, 0, 1'b1);
    ticks(3);
    send(2'd1, A, MC, 4'b0001, 1'b1, 0, 1'b1);
    ticks(1);
    send(2'd1, A, MC, 4'b1101, 1'b0, 0, 1'b1);

    // Collision: B overwrites A in the same slot.
    send(2'd0, BC, A, 4'b1110, 1'b0, 0, 1'b1);
    chk("no_evict_before_collision", 32'(evict_cnt), 32'd0);
    send(2'd2, BC, B, 4'b1011, 1'b0, 0, 1'b1);
    chk("evict_once", 32'(evict_cnt), 32'd1);
    send(2'd0, A, MC, 4'b1110, 1'b0, 0, 1'b1);
    send(2'd0, B, MC, 4'b0100, 1'b1, 0, 1'b1);
    chk("evict_total", 32'(evict_cnt), 32'd1);

    // Flush during LOOKUP: in-flight lookup uses old contents, learn suppressed.
    send(2'd0, B, A, 4'b0100, 1'b1, 2, 1'b1);
    send(2'd1, A, MC, 4'b1101, 1'b0, 0, 1'b1);
    send(2'd0, B, MC, 4'b1110, 1'b0, 0, 1'b1);

    // Backpressure: response held stable, no new request accepted.
    resp_ready = 1'b0;
    send(2'd3, BC, A, 4'b0111, 1'b0, 0, 1'b0);
    wait_resp_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_mask",      32'(resp_mask),  32'h7);
      chk("hold_req_ready", 32'(req_ready),  32'd0);
      chk("hold_valid",     32'(resp_valid), 32'd1);
    end
    resp_ready = 1'b1;
    drain();

    // Reset while in RESP drops the response and empties the table.
    resp_ready = 1'b0;
    send(2'd0, BC, MC, 4'b1110, 1'b0, 0, 1'b0);
    wait_resp_valid();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready",  32'(req_ready),  32'd1);
    chk("midrst_mask",       32'(resp_mask),  32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    step();
    send(2'd1, A, MC, 4'b1101, 1'b0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
